// File: rtl/mips_runctl_pkg.sv
// Shared definitions for the MIPS program-load / run controller:
// controller state encoding, default geometry and the word-counter width helper.
package mips_runctl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StRstHold = 3'd2,
    StRun     = 3'd3,
    StDone    = 3'd4
  } run_state_e;

  localparam int unsigned DefImemDepth    = 256;
  localparam int unsigned DefHaltStable   = 4;
  localparam int unsigned DefCpuRstCycles = 2;

  // Counter must hold the value depth itself, hence depth + 1.
  function automatic int unsigned word_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mips_pc_halt_det.sv
// PC-stability halt detector: flags a halt when the CPU PC has been unchanged for
// HALT_STABLE consecutive cycle-to-cycle comparisons while enabled. The first enabled
// cycle only primes the previous-PC register so a PC held at 0 by reset is not counted.
module mips_pc_halt_det
  import mips_runctl_pkg::*;
#(
  parameter int unsigned HALT_STABLE = DefHaltStable
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic [31:0] cpu_pc,
  output logic        halt
);

  logic [31:0] prev_pc_q;
  logic        prev_vld_q;
  logic [3:0]  stable_q, stable_d;
  logic        same;

  assign same = enable && prev_vld_q && (cpu_pc == prev_pc_q);
  // Fires once: the counter saturates past the firing value.
  assign halt = same && (stable_q == 4'(HALT_STABLE - 1));

  // Stable-run counter: cleared on any PC change or while disabled.
  always_comb begin
    stable_d = stable_q;
    if (!same) begin
      stable_d = '0;
    end else if (stable_q != 4'(HALT_STABLE)) begin
      stable_d = stable_q + 4'd1;
    end
  end

  // Previous-PC, valid flag and counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      stable_q   <= '0;
    end else begin
      prev_pc_q  <= cpu_pc;
      prev_vld_q <= enable;
      stable_q   <= stable_d;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Program-load and run controller for SingleCycleClockMIPS. Streams instruction words
// into the CPU IMem over W_Ins/WE with the CPU held in reset, releases it, and ends the
// run on PC halt or cycle budget, capturing the final Result.
// Optional build macro: MIPS_RUNCTL_PC_TRAP_EN adds trap_pc/trapped (PC breakpoint).
module mips_run_ctrl
  import mips_runctl_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH     = DefImemDepth,
  parameter int unsigned CW             = 16,
  parameter int unsigned HALT_STABLE    = DefHaltStable,
  parameter int unsigned CPU_RST_CYCLES = DefCpuRstCycles
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic [CW-1:0] max_cycles,
  input  logic [31:0]   cpu_pc,
  input  logic [31:0]   cpu_result,
`ifdef MIPS_RUNCTL_PC_TRAP_EN
  input  logic [31:0]   trap_pc,
  output logic          trapped,
`endif
  output logic          cpu_rst,
  output logic [31:0]   cpu_w_ins,
  output logic          cpu_we,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic [31:0]   last_result
);

  localparam int unsigned AW = word_cnt_width(IMEM_DEPTH);
  localparam logic [CW-1:0] CycOne = CW'(1);

  run_state_e    state_q, state_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [3:0]    hold_q, hold_d;
  logic [CW-1:0] max_q, max_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   last_result_q, last_result_d;
  logic [31:0]   w_ins_q, w_ins_d;
  logic          we_q, we_d;
  logic          hs, run, halt, budget, trap_hit;

`ifdef MIPS_RUNCTL_PC_TRAP_EN
  logic trapped_q, trapped_d;
  assign trap_hit = run && (cpu_pc == trap_pc);
  assign trapped  = trapped_q;
`else
  assign trap_hit = 1'b0;
`endif

  assign run      = (state_q == StRun);
  assign ld_ready = (state_q == StLoad) && (word_cnt_q < AW'(IMEM_DEPTH));
  assign hs       = ld_valid && ld_ready;
  // Budget ends the run on the edge that makes cycles equal max_cycles.
  assign budget   = run && (max_q != '0) && (cycles_q == max_q - CycOne);

  mips_pc_halt_det #(
    .HALT_STABLE(HALT_STABLE)
  ) u_halt_det (
    .CLK   (CLK),
    .RST_N (RST_N),
    .enable(run),
    .cpu_pc(cpu_pc),
    .halt  (halt)
  );

  // Next-state and datapath updates for the load/run sequence.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    hold_d        = hold_q;
    max_d         = max_q;
    cycles_d      = cycles_q;
    timeout_d     = timeout_q;
    last_result_d = last_result_q;
    w_ins_d       = w_ins_q;
    we_d          = 1'b0;
`ifdef MIPS_RUNCTL_PC_TRAP_EN
    trapped_d     = trapped_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          word_cnt_d = '0;
          cycles_d   = '0;
          timeout_d  = 1'b0;
          max_d      = max_cycles;
`ifdef MIPS_RUNCTL_PC_TRAP_EN
          trapped_d  = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (hs) begin
          w_ins_d    = ld_data;
          we_d       = 1'b1;
          word_cnt_d = word_cnt_q + AW'(1);
          // The final WE pulse lands in the first hold cycle, still under CPU reset.
          if (ld_last || (word_cnt_q == AW'(IMEM_DEPTH - 1))) begin
            state_d = StRstHold;
            hold_d  = '0;
          end
        end
      end
      StRstHold: begin
        if (hold_q == 4'(CPU_RST_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      StRun: begin
        if (cycles_q != '1) begin
          cycles_d = cycles_q + CycOne;
        end
        if (trap_hit || halt || budget) begin
          state_d       = StDone;
          last_result_d = cpu_result;
          timeout_d     = budget && !halt && !trap_hit;
`ifdef MIPS_RUNCTL_PC_TRAP_EN
          trapped_d     = trap_hit;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      word_cnt_q    <= '0;
      hold_q        <= '0;
      max_q         <= '0;
      cycles_q      <= '0;
      timeout_q     <= 1'b0;
      last_result_q <= '0;
      w_ins_q       <= '0;
      we_q          <= 1'b0;
`ifdef MIPS_RUNCTL_PC_TRAP_EN
      trapped_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      hold_q        <= hold_d;
      max_q         <= max_d;
      cycles_q      <= cycles_d;
      timeout_q     <= timeout_d;
      last_result_q <= last_result_d;
      w_ins_q       <= w_ins_d;
      we_q          <= we_d;
`ifdef MIPS_RUNCTL_PC_TRAP_EN
      trapped_q     <= trapped_d;
`endif
    end
  end

  assign cpu_rst     = (state_q != StRun);
  assign busy        = (state_q == StLoad) || (state_q == StRstHold) || (state_q == StRun);
  assign done        = (state_q == StDone);
  assign timeout     = timeout_q;
  assign cycles      = cycles_q;
  assign last_result = last_result_q;
  assign cpu_w_ins   = w_ins_q;
  assign cpu_we      = we_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a tiny behavioural MIPS (addi / j only) and a
// scoreboard pairing each load handshake with the WE pulse it must produce one cycle later.
module tb_mips_run_ctrl;

  logic        CLK, RST_N, start, ld_valid, ld_ready, ld_last;
  logic [31:0] ld_data, cpu_pc, cpu_result, cpu_w_ins, last_result;
  logic [15:0] max_cycles, cycles;
  logic        cpu_rst, cpu_we, busy, done, timeout;
`ifdef MIPS_RUNCTL_PC_TRAP_EN
  logic [31:0] trap_pc;
  logic        trapped;
`endif

  mips_run_ctrl #(
    .IMEM_DEPTH(4),
    .CW(16),
    .HALT_STABLE(4),
    .CPU_RST_CYCLES(2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .max_cycles (max_cycles),
    .cpu_pc     (cpu_pc),
    .cpu_result (cpu_result),
`ifdef MIPS_RUNCTL_PC_TRAP_EN
    .trap_pc    (trap_pc),
    .trapped    (trapped),
`endif
    .cpu_rst    (cpu_rst),
    .cpu_w_ins  (cpu_w_ins),
    .cpu_we     (cpu_we),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles),
    .last_result(last_result)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural CPU: IMem written sequentially while in reset, addi/j executed otherwise.
  logic [31:0] imem [256];
  logic [31:0] regs [32];
  logic [7:0]  wptr;
  logic [31:0] ins;
  assign ins        = imem[cpu_pc[9:2]];
  assign cpu_result = regs[9];

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    wptr   = '0;
    cpu_pc = '0;
  end

  always @(posedge CLK) begin
    if (cpu_rst) begin
      cpu_pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      if (cpu_we) begin
        imem[wptr] <= cpu_w_ins;
        wptr <= wptr + 8'd1;
      end
    end else begin
      wptr <= '0;
      if (ins[31:26] == 6'h02) begin
        cpu_pc <= {cpu_pc[31:28], ins[25:0], 2'b00};
      end else begin
        if (ins[31:26] == 6'h08 && ins[20:16] != 5'd0)
          regs[ins[20:16]] <= regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
        cpu_pc <= cpu_pc + 32'd4;
      end
    end
  end

  // Scoreboard: handshake pushes (data, edge index at which WE must be visible).
  typedef struct {
    logic [31:0] data;
    int          edge_idx;
  } sb_t;
  sb_t sb[$];
  int  edges = 0;
  int  we_count = 0;
  sb_t ent;

  always @(posedge CLK) begin
    if (ld_valid && ld_ready) sb.push_back('{ld_data, edges + 1});
    edges++;
  end

  always @(negedge CLK) begin
    if (cpu_we) begin
      we_count++;
      check("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() != 0) begin
        ent = sb.pop_front();
        check("we_data", cpu_w_ins, ent.data);
        check("we_latency", edges, ent.edge_idx);
      end
    end
  end

  logic [31:0] prog [8];

  task automatic pulse_start(input logic [15:0] m);
    we_count = 0;
    start = 1'b1;
    max_cycles = m;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic load(input int n, input bit use_last, output int acc, output logic post_hold);
    int k;
    acc = 0;
    post_hold = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = use_last && (i == n - 1);
      k = 0;
      while (!ld_ready && k < 5) begin
        @(negedge CLK);
        k++;
      end
      if (!ld_ready) break;
      @(negedge CLK);
      acc++;
      post_hold = busy && cpu_rst && !ld_ready;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_done(output int runs);
    int n;
    runs = 0;
    n = 0;
    while (!done && n < 200) begin
      if (!cpu_rst) runs++;
      @(negedge CLK);
      n++;
    end
    check("done_reached", done, 1);
  endtask

  int   runs, acc, k;
  logic ph;

  initial begin
    RST_N = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; max_cycles = '0;
`ifdef MIPS_RUNCTL_PC_TRAP_EN
    trap_pc = 32'hFFFF_FFFC;
`endif
    #1;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_we", cpu_we, 0);
    check("rst_w_ins", cpu_w_ins, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycles", cycles, 0);
    check("rst_last_result", last_result, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Program 1: t1=5; t1=t1+1; j 2 (spins at 0x8)
    prog = '{32'h20090005, 32'h21290001, 32'h08000002, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pulse_start(16'd0);
    check("t1_start_busy", busy, 1);
    check("t1_start_ready", ld_ready, 1);
    load(3, 1'b1, acc, ph);
    check("t1_accepted", acc, 3);
    check("t1_hold_entry", ph, 1);
    @(negedge CLK);
    check("t1_hold2_rst", cpu_rst, 1);
    check("t1_hold2_we", cpu_we, 0);
    @(negedge CLK);
    check("t1_run_rst", cpu_rst, 0);
    wait_done(runs);
    check("t1_runs", runs, 7);
    check("t1_cycles", cycles, 7);
    check("t1_timeout", timeout, 0);
    check("t1_result", last_result, 32'h6);
    check("t1_done_rst", cpu_rst, 1);
    check("t1_busy", busy, 0);
    check("t1_we_count", we_count, 3);
    check("t1_sb_empty", sb.size(), 0);

    // Program 2 never settles: budget of 10 run cycles
    prog = '{32'h20090005, 32'h08000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pulse_start(16'd10);
    check("t2_done_clr", done, 0);
    check("t2_cycles_clr", cycles, 0);
    check("t2_result_kept", last_result, 32'h6);
    load(2, 1'b1, acc, ph);
    wait_done(runs);
    check("t2_runs", runs, 10);
    check("t2_cycles", cycles, 10);
    check("t2_timeout", timeout, 1);
    check("t2_cpu_rst", cpu_rst, 1);
    check("t2_we_count", we_count, 2);

    // Depth limit: 6 words, no ld_last, only 4 accepted
    prog = '{32'h20090005, 32'h21290001, 32'h08000002, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF,
             32'h0, 32'h0};
    pulse_start(16'd0);
    load(6, 1'b0, acc, ph);
    check("t3_accepted", acc, 4);
    check("t3_hold_entry", ph, 1);
    check("t3_we_count", we_count, 4);
    wait_done(runs);
    check("t3_result", last_result, 32'h6);
    check("t3_cycles", cycles, 7);

    // Halt and budget coincide: halt wins
    prog = '{32'h20090005, 32'h21290001, 32'h08000002, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pulse_start(16'd7);
    load(3, 1'b1, acc, ph);
    wait_done(runs);
    check("t4_same_timeout", timeout, 0);
    check("t4_same_cycles", cycles, 7);
    // Budget one cycle before halt
    pulse_start(16'd6);
    load(3, 1'b1, acc, ph);
    wait_done(runs);
    check("t4_early_timeout", timeout, 1);
    check("t4_early_cycles", cycles, 6);

    // start held through LOAD and pulsed in RUN must be ignored (max_cycles changes too)
    we_count = 0;
    start = 1'b1;
    max_cycles = 16'd0;
    @(negedge CLK);
    max_cycles = 16'd3;
    load(3, 1'b1, acc, ph);
    start = 1'b0;
    k = 0;
    while (cpu_rst && k < 10) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    max_cycles = 16'd0;
    wait_done(runs);
    check("t5_timeout", timeout, 0);
    check("t5_cycles", cycles, 7);
    check("t5_we_count", we_count, 3);

    // Asynchronous reset mid-RUN, then a clean reload
    prog = '{32'h20090005, 32'h08000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pulse_start(16'd0);
    load(2, 1'b1, acc, ph);
    k = 0;
    while (cpu_rst && k < 10) begin
      @(negedge CLK);
      k++;
    end
    repeat (3) @(negedge CLK);
    check("t6_in_run", cpu_rst, 0);
    #2 RST_N = 1'b0;
    #1;
    check("t6_rst_cpu_rst", cpu_rst, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_cycles", cycles, 0);
    check("t6_rst_result", last_result, 0);
    check("t6_rst_w_ins", cpu_w_ins, 0);
    check("t6_rst_ready", ld_ready, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("t6_idle_busy", busy, 0);
    prog = '{32'h20090005, 32'h21290001, 32'h08000002, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pulse_start(16'd0);
    load(3, 1'b1, acc, ph);
    wait_done(runs);
    check("t6_reload_result", last_result, 32'h6);
    check("t6_reload_cycles", cycles, 7);

`ifdef MIPS_RUNCTL_PC_TRAP_EN
    // PC trap at 0x4: run ends in RUN cycle 2 with t1=5
    trap_pc = 32'h4;
    pulse_start(16'd0);
    load(3, 1'b1, acc, ph);
    wait_done(runs);
    check("t7_trapped", trapped, 1);
    check("t7_timeout", timeout, 0);
    check("t7_cycles", cycles, 2);
    check("t7_result", last_result, 32'h5);
    trap_pc = 32'hFFFF_FFFC;
    pulse_start(16'd0);
    check("t7_trap_clr", trapped, 0);
    load(3, 1'b1, acc, ph);
    wait_done(runs);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Synthesizable program-load and run controller for SingleCycleClockMIPS. It streams instruction words into the CPU instruction memory over the existing W_Ins/WE port and holds the CPU in reset while doing so. It then releases the CPU, runs it, and detects halt (PC stable) or timeout, and captures the final Result. It sits between a host stream (UART/JTAG bridge or bench) and the CPU, replacing hand-poked register and memory initialisation.

Parameters:
IMEM_DEPTH, 256, maximum instruction words accepted per load.
CW, 16, width of the cycle counter and cycle budget.
HALT_STABLE, 4, consecutive cycles with unchanged PC that count as a halt (2..15).
CPU_RST_CYCLES, 2, cycles the CPU reset is held after load before the run starts (1..15).

Ports:
CLK  in  1  clock.
RST_N  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins load then run; honoured only in IDLE and DONE.
ld_valid  in  1  host word valid.
ld_ready  out  1  controller accepts a word.
ld_data  in  32  instruction word.
ld_last  in  1  marks the final word of the program.
max_cycles  in  CW  run budget; 0 means unlimited; sampled on start.
cpu_pc  in  32  PC from the CPU.
cpu_result  in  32  Result from the CPU.
cpu_rst  out  1  active-high reset to the CPU.
cpu_w_ins  out  32  to CPU W_Ins.
cpu_we  out  1  to CPU WE.
busy  out  1  high in LOAD, RST_HOLD and RUN.
done  out  1  high in DONE.
timeout  out  1  valid with done; 1 means the budget was exhausted.
cycles  out  CW  run cycles elapsed; saturates at all-ones.
last_result  out  32  cpu_result captured on entry to DONE.

Behaviour:
- Reset (asynchronous, on RST_N low):
  - State goes to IDLE.
  - cpu_rst=1 immediately.
  - cpu_we=0, cpu_w_ins=0, ld_ready=0, busy=0, done=0, timeout=0, cycles=0, last_result=0.
- States: IDLE, LOAD, RST_HOLD, RUN, DONE.
- cpu_rst is 0 only in RUN.
- IMem write rule: the CPU IMem writes sequentially from word 0 on each WE pulse while in reset.
- IDLE/DONE + start:
  - Go to LOAD.
  - Clear done, timeout and cycles; keep last_result.
  - Latch max_cycles.
  - start in any other state is ignored.
- LOAD:
  - ld_ready=1 while word count < IMEM_DEPTH.
  - Each handshake (ld_valid & ld_ready) registers cpu_w_ins<=ld_data and cpu_we<=1 on the next edge, so there is one-cycle latency.
  - cpu_we is a single-cycle pulse per word.
  - Back-to-back words give WE high on consecutive cycles.
  - Exit to RST_HOLD on the cycle after accepting ld_last, or after accepting word IMEM_DEPTH. After that, ld_ready=0; excess words are not accepted.
  - ld_valid without ld_last leaves LOAD waiting indefinitely.
- RST_HOLD:
  - cpu_we=0.
  - Count CPU_RST_CYCLES cycles, then go to RUN.
- RUN:
  - cycles increments every cycle.
  - The halt detector compares cpu_pc with its previous value. When unchanged for HALT_STABLE consecutive cycles, raise halt.
  - If max_cycles!=0 and cycles==max_cycles-1 on this edge, raise budget-exhausted.
  - Either event leads to DONE on the next edge, with last_result<=cpu_result.
  - timeout=1 only if budget-exhausted without halt. If both occur in the same cycle, halt wins and timeout=0.
- DONE:
  - cpu_rst=1, done=1.
  - Outputs hold until start or reset.
- Reset mid-operation aborts; the CPU IMem contents are not cleared.

Optional Feature:
MIPS_RUNCTL_PC_TRAP_EN
- Enabled:
  - Adds input trap_pc[31:0] and output trapped.
  - In RUN, cpu_pc==trap_pc ends the run that cycle, giving DONE next edge with trapped=1 and timeout=0.
  - Priority: trap > halt > timeout.
  - trapped is cleared on start and on reset.
- Disabled: no trap_pc or trapped ports; halt and timeout only.

Decomposition:
- Shared package mips_runctl_pkg holds:
  - state encoding (IDLE=0, LOAD=1, RST_HOLD=2, RUN=3, DONE=4), 3 bits;
  - the default HALT_STABLE, CPU_RST_CYCLES and IMEM_DEPTH constants;
  - the address-width function clog2(IMEM_DEPTH+1) for the word counter.
- One sub-module, mips_pc_halt_det:
  - inputs: CLK, RST_N, enable (RUN), cpu_pc;
  - holds the previous-PC register and stable counter;
  - outputs a one-cycle halt;
  - counter is cleared when enable is low.

Test Plan:
- Load 3 words 0x20090005, 0x21290001, 0x08000002 with ld_last on word 3, then run until done. Expected:
  - cpu_we pulses 3 times with data in order, each one cycle after its handshake;
  - cpu_rst stays 1 for 2 cycles after the load, then 0;
  - after the PC settles at 0x8 for 4 cycles: done=1, timeout=0, last_result=0x00000006.
- max_cycles=10 with a program that never settles its PC -> DONE after exactly 10 RUN cycles, cycles=10, timeout=1, cpu_rst=1.
- IMEM_DEPTH=4 and 6 words streamed with no ld_last -> 4 WE pulses, ld_ready=0 after the 4th word, state goes to RST_HOLD.
- Halt and budget exhaustion in the same cycle (max_cycles tuned to match) -> done=1, timeout=0.
- RST_N low for 1 cycle mid-RUN -> cpu_rst=1 before the next edge, all outputs at reset values, state IDLE; a new start reloads correctly.
- start pulsed during LOAD and during RUN -> ignored; with MIPS_RUNCTL_PC_TRAP_EN and trap_pc=0x4, the run stops with trapped=1 when the PC reaches 0x4.
